// File: rtl/matrix_pwm_scheduler.sv
// Per-output-phase A/B/C dwell scheduler feeding DesiredLoad of one
// matrix-converter commutation FSM, with min-dwell folding and fault safing.
module matrix_pwm_scheduler #(
  parameter int CNT_W     = 12,
  parameter int MIN_DWELL = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] duty_a,
  input  logic [CNT_W-1:0] duty_b,
  input  logic [CNT_W-1:0] duty_c,
  input  logic             fault,
  output logic [1:0]       DesiredLoad,
  output logic             fsm_rst,
  output logic             period_start,
  output logic             cfg_err,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN_A,
    S_RUN_B,
    S_RUN_C,
    S_SAFE
  } state_e;

  localparam logic [CNT_W+1:0] MIN_PER = (CNT_W+2)'(3*MIN_DWELL);
  localparam logic [CNT_W-1:0] MIN_D   = CNT_W'(MIN_DWELL);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] sh_a_q, sh_a_d;
  logic [CNT_W-1:0] sh_b_q, sh_b_d;
  logic [CNT_W-1:0] sh_c_q, sh_c_d;
  logic [CNT_W-1:0] ea_q, ea_d;
  logic [CNT_W-1:0] eb_q, eb_d;
  logic [CNT_W-1:0] ec_q, ec_d;
  logic             pend_q, pend_d;
  logic             has_q, has_d;
  logic             ps_q, ps_d;
  logic             err_q, err_d;

  logic [CNT_W+1:0] sum;
  logic             cfg_ok;
  logic             accept;
  logic             sk_a, sk_b, sk_c;
  logic [CNT_W-1:0] fa, fb, fc;
  logic [CNT_W-1:0] na, nb, nc;
  logic             start;
  logic             wrap;

  assign sum = {2'b00, duty_a} + {2'b00, duty_b}
             + {2'b00, duty_c};
  assign cfg_ok = (sum == {2'b00, period})
               && ({2'b00, period} >= MIN_PER);
  assign cfg_ready = ~pend_q;
  assign accept    = cfg_valid & ~pend_q;

  // Short dwells fold into the nearest preceding kept segment,
  // or the nearest following one when nothing precedes.
  always_comb begin
    sk_a = sh_a_q < MIN_D;
    sk_b = sh_b_q < MIN_D;
    sk_c = sh_c_q < MIN_D;
    fa = sk_a ? '0 : sh_a_q;
    fb = sk_b ? '0 : sh_b_q;
    fc = sk_c ? '0 : sh_c_q;
    if (sk_a) begin
      if (!sk_b) fb = fb + sh_a_q;
      else       fc = fc + sh_a_q;
    end
    if (sk_b) begin
      if (!sk_a) fa = fa + sh_b_q;
      else       fc = fc + sh_b_q;
    end
    if (sk_c) begin
      if (!sk_b) fb = fb + sh_c_q;
      else       fa = fa + sh_c_q;
    end
  end

  assign na = pend_q ? fa : ea_q;
  assign nb = pend_q ? fb : eb_q;
  assign nc = pend_q ? fc : ec_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_a_d  = sh_a_q;
    sh_b_d  = sh_b_q;
    sh_c_d  = sh_c_q;
    ea_d    = ea_q;
    eb_d    = eb_q;
    ec_d    = ec_q;
    pend_d  = pend_q;
    has_d   = has_q;
    ps_d    = 1'b0;
    err_d   = 1'b0;
    start   = 1'b0;
    wrap    = 1'b0;

    if (accept) begin
      if (cfg_ok) begin
        sh_a_d = duty_a;
        sh_b_d = duty_b;
        sh_c_d = duty_c;
        pend_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end

    if (fault) begin
      state_d = S_SAFE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (en && (has_q || pend_q)) start = 1'b1;
        end
        S_RUN_A: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - ONE;
          end else if (eb_q != '0) begin
            state_d = S_RUN_B;
            cnt_d   = eb_q - ONE;
          end else if (ec_q != '0) begin
            state_d = S_RUN_C;
            cnt_d   = ec_q - ONE;
          end else begin
            wrap = 1'b1;
          end
        end
        S_RUN_B: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - ONE;
          end else if (ec_q != '0) begin
            state_d = S_RUN_C;
            cnt_d   = ec_q - ONE;
          end else begin
            wrap = 1'b1;
          end
        end
        S_RUN_C: begin
          if (cnt_q != '0) cnt_d = cnt_q - ONE;
          else             wrap  = 1'b1;
        end
        S_SAFE: begin
          if (!en) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (wrap) begin
      if (en) start   = 1'b1;
      else    state_d = S_IDLE;
    end

    if (start) begin
      if (pend_q) begin
        ea_d   = fa;
        eb_d   = fb;
        ec_d   = fc;
        pend_d = 1'b0;
        has_d  = 1'b1;
      end
      ps_d = 1'b1;
      if (na != '0) begin
        state_d = S_RUN_A;
        cnt_d   = na - ONE;
      end else if (nb != '0) begin
        state_d = S_RUN_B;
        cnt_d   = nb - ONE;
      end else begin
        state_d = S_RUN_C;
        cnt_d   = nc - ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      sh_c_q  <= '0;
      ea_q    <= '0;
      eb_q    <= '0;
      ec_q    <= '0;
      pend_q  <= 1'b0;
      has_q   <= 1'b0;
      ps_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_a_q  <= sh_a_d;
      sh_b_q  <= sh_b_d;
      sh_c_q  <= sh_c_d;
      ea_q    <= ea_d;
      eb_q    <= eb_d;
      ec_q    <= ec_d;
      pend_q  <= pend_d;
      has_q   <= has_d;
      ps_q    <= ps_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    DesiredLoad = 2'b00;
    fsm_rst     = 1'b1;
    busy        = 1'b0;
    unique case (state_q)
      S_RUN_A: begin
        DesiredLoad = 2'b01;
        fsm_rst     = 1'b0;
        busy        = 1'b1;
      end
      S_RUN_B: begin
        DesiredLoad = 2'b10;
        fsm_rst     = 1'b0;
        busy        = 1'b1;
      end
      S_RUN_C: begin
        DesiredLoad = 2'b11;
        fsm_rst     = 1'b0;
        busy        = 1'b1;
      end
      default: begin
        DesiredLoad = 2'b00;
      end
    endcase
  end

  assign period_start = ps_q;
  assign cfg_err      = err_q;

endmodule

// File: tb/tb_matrix_pwm_scheduler.sv
// Bench for matrix_pwm_scheduler: vector table, corner sequences and a
// randomized run against a per-cycle schedule model.
module tb_matrix_pwm_scheduler;
  localparam int W  = 12;
  localparam int MD = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [W-1:0] period;
  logic [W-1:0] duty_a;
  logic [W-1:0] duty_b;
  logic [W-1:0] duty_c;
  logic         fault;
  logic [1:0]   DesiredLoad;
  logic         fsm_rst;
  logic         period_start;
  logic         cfg_err;
  logic         busy;

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  typedef struct {
    int p, a, b, c;
    int ok;
    int ea, eb, ec;
  } vec_t;

  vec_t tbl[13];

  always #5 clk = ~clk;

  matrix_pwm_scheduler #(.CNT_W(W), .MIN_DWELL(MD)) dut (
    .clk(clk), .rst(rst), .en(en),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .period(period), .duty_a(duty_a),
    .duty_b(duty_b), .duty_c(duty_c),
    .fault(fault), .DesiredLoad(DesiredLoad),
    .fsm_rst(fsm_rst), .period_start(period_start),
    .cfg_err(cfg_err), .busy(busy)
  );

  task automatic chk(input string nm, input int act,
                     input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int valid(input int p, a, b, c);
    return ((a + b + c) == p && p >= 3*MD) ? 1 : 0;
  endfunction

  // Expected per-cycle DesiredLoad codes for one period.
  function automatic void model(input int p, a, b, c);
    int d[3];
    int e[3];
    int sk[3];
    int tgt;
    d[0] = a; d[1] = b; d[2] = c;
    for (int i = 0; i < 3; i++) begin
      sk[i] = (d[i] < MD) ? 1 : 0;
      e[i]  = sk[i] ? 0 : d[i];
    end
    for (int i = 0; i < 3; i++) begin
      if (sk[i] != 0 && d[i] > 0) begin
        tgt = -1;
        for (int j = i - 1; j >= 0; j--)
          if (sk[j] == 0 && tgt < 0) tgt = j;
        for (int j = i + 1; j < 3; j++)
          if (sk[j] == 0 && tgt < 0) tgt = j;
        if (tgt >= 0) e[tgt] += d[i];
      end
    end
    exp_q.delete();
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < e[i]; k++) exp_q.push_back(i + 1);
  endfunction

  task automatic do_reset();
    rst = 1'b0; en = 1'b0; cfg_valid = 1'b0; fault = 1'b0;
    period = '0; duty_a = '0; duty_b = '0; duty_c = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dl", DesiredLoad, 0);
    chk("rst_fsmrst", fsm_rst, 1);
    chk("rst_ps", period_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdy", cfg_ready, 1);
    chk("rst_err", cfg_err, 0);
    rst = 1'b1;
    tick();
  endtask

  task automatic drive_cfg(input int p, a, b, c);
    period = W'(p); duty_a = W'(a);
    duty_b = W'(b); duty_c = W'(c);
    cfg_valid = 1'b1;
  endtask

  task automatic offer(input int p, a, b, c);
    drive_cfg(p, a, b, c);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_start(input string nm);
    int n = 0;
    while (!period_start && n < 10) begin
      tick();
      n++;
    end
    chk({nm, "_start"}, period_start, 1);
  endtask

  task automatic drain(input string nm);
    int n = 0;
    en = 1'b0;
    while (busy && n < 500) begin
      tick();
      n++;
    end
    chk({nm, "_drain"}, busy, 0);
  endtask

  task automatic measure(input int len, output int ca, cb, cc,
                         output int nb);
    ca = 0; cb = 0; cc = 0; nb = 0;
    for (int i = 0; i < len; i++) begin
      if (DesiredLoad == 2'b01) ca++;
      if (DesiredLoad == 2'b10) cb++;
      if (DesiredLoad == 2'b11) cc++;
      if (period_start != (i == 0)) nb++;
      if (fsm_rst) nb++;
      tick();
    end
  endtask

  task automatic post(input string nm, input int ok);
    chk({nm, "_err"}, cfg_err, ok ? 0 : 1);
    chk({nm, "_rdy"}, cfg_ready, ok ? 0 : 1);
    cfg_valid = 1'b0;
  endtask

  // One period against the model; optionally offer a config at cycle oc.
  task automatic play(input string nm, input int p, a, b, c,
                      input int oc, input int np, na, nb, nc);
    int mism = 0;
    int ok;
    int len;
    ok = valid(np, na, nb, nc);
    model(p, a, b, c);
    len = exp_q.size();
    for (int i = 0; i < len; i++) begin
      if (int'(DesiredLoad) != exp_q[i]) mism++;
      if (period_start != (i == 0)) mism++;
      if (fsm_rst) mism++;
      if (oc >= 0 && i == oc + 1) post(nm, ok);
      if (i == oc) drive_cfg(np, na, nb, nc);
      tick();
    end
    if (oc >= 0 && oc + 1 == len) post(nm, ok);
    chk({nm, "_seq"}, mism, 0);
  endtask

  initial begin
    int ca, cb, cc, nbad, cnt;
    int cp, cA, cB, cC;
    int np, na, nb, nc, oc;
    string nm;

    tbl = '{
      '{100, 30,   50,  20, 1,  30,  50,  20},
      '{100,  5,   75,  20, 1,   0,  80,  20},
      '{100, 30,   65,   5, 1,  30,  70,   0},
      '{100, 30,   30,  30, 0,   0,   0,   0},
      '{ 23,  8,    8,   7, 0,   0,   0,   0},
      '{ 24,  8,    8,   8, 1,   8,   8,   8},
      '{100,  0,  100,   0, 1,   0, 100,   0},
      '{100,  7,    7,  86, 1,   0,   0, 100},
      '{100, 50,    7,  43, 1,  57,   0,  43},
      '{100, 50,   43,   7, 1,  50,  50,   0},
      '{100, 90,    3,   7, 1, 100,   0,   0},
      '{100, 4000, 96, 100, 0,   0,   0,   0},
      '{ 30,  3,   20,   7, 1,   0,  30,   0}
    };

    foreach (tbl[i]) begin
      nm = $sformatf("v%0d", i);
      do_reset();
      offer(tbl[i].p, tbl[i].a, tbl[i].b, tbl[i].c);
      chk({nm, "_err"}, cfg_err, tbl[i].ok ? 0 : 1);
      chk({nm, "_rdy"}, cfg_ready, tbl[i].ok ? 0 : 1);
      tick();
      chk({nm, "_errpulse"}, cfg_err, 0);
      if (tbl[i].ok != 0) begin
        en = 1'b1;
        wait_start(nm);
        measure(tbl[i].p, ca, cb, cc, nbad);
        chk({nm, "_A"}, ca, tbl[i].ea);
        chk({nm, "_B"}, cb, tbl[i].eb);
        chk({nm, "_C"}, cc, tbl[i].ec);
        chk({nm, "_ctl"}, nbad, 0);
        chk({nm, "_next_ps"}, period_start, 1);
        drain(nm);
      end
    end

    // Reconfiguration while running, incl. offer on the last cycle.
    do_reset();
    offer(100, 30, 50, 20);
    en = 1'b1;
    wait_start("d0");
    play("d1", 100, 30, 50, 20, -1, 0, 0, 0, 0);
    play("d2", 100, 30, 50, 20, 20, 100, 30, 30, 30);
    play("d3", 100, 30, 50, 20, 50, 60, 20, 20, 20);
    chk("d3_rdy_boundary", cfg_ready, 1);
    play("d4", 60, 20, 20, 20, 59, 100, 30, 50, 20);
    play("d5", 60, 20, 20, 20, -1, 0, 0, 0, 0);
    play("d6", 100, 30, 50, 20, -1, 0, 0, 0, 0);

    // Fault in segment B.
    repeat (40) tick();
    chk("f_inB", DesiredLoad, 2);
    fault = 1'b1;
    tick();
    chk("f_dl", DesiredLoad, 0);
    chk("f_fsmrst", fsm_rst, 1);
    chk("f_busy", busy, 0);
    fault = 1'b0;
    cnt = 0;
    repeat (5) begin
      tick();
      cnt += int'(busy) + int'(period_start);
    end
    chk("f_hold_safe", cnt, 0);
    en = 1'b0;
    tick();
    chk("f_idle_busy", busy, 0);
    en = 1'b1;
    tick();
    chk("f_restart_ps", period_start, 1);
    chk("f_restart_dl", DesiredLoad, 1);

    // en dropped at cycle 10: period completes.
    repeat (10) tick();
    en = 1'b0;
    cnt = 0;
    for (int i = 10; i < 100; i++) begin
      cnt += int'(busy);
      tick();
    end
    chk("e_busy_cycles", cnt, 90);
    chk("e_end_busy", busy, 0);
    chk("e_end_dl", DesiredLoad, 0);
    chk("e_end_fsmrst", fsm_rst, 1);
    chk("e_end_ps", period_start, 0);

    // Asynchronous reset in the middle of segment B.
    en = 1'b1;
    wait_start("r0");
    repeat (40) tick();
    chk("r_inB", DesiredLoad, 2);
    #2 rst = 1'b0;
    #1;
    chk("r_async_dl", DesiredLoad, 0);
    chk("r_async_fsmrst", fsm_rst, 1);
    chk("r_async_busy", busy, 0);
    chk("r_async_rdy", cfg_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    cnt = 0;
    repeat (20) begin
      tick();
      cnt += int'(busy) + int'(period_start);
    end
    chk("r_no_cfg_idle", cnt, 0);
    offer(100, 30, 50, 20);
    wait_start("r1");
    chk("r1_dl", DesiredLoad, 1);

    // Randomized reconfiguration against the model.
    cp = 100; cA = 30; cB = 50; cC = 20;
    repeat (25) begin
      np = $urandom_range(24, 200);
      na = $urandom_range(0, np);
      if ($urandom_range(0, 3) == 0) na = $urandom_range(0, MD - 1);
      nb = $urandom_range(0, np - na);
      if ($urandom_range(0, 3) == 0 && np - na >= MD)
        nb = $urandom_range(0, MD - 1);
      nc = np - na - nb;
      if ($urandom_range(0, 4) == 0) nc = nc + 1;
      oc = $urandom_range(0, cp - 2);
      play("rnd", cp, cA, cB, cC, oc, np, na, nb, nc);
      if (valid(np, na, nb, nc) != 0) begin
        cp = np; cA = na; cB = nb; cC = nc;
      end
    end
    drain("rnd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
